obstacle_scroller: RTL and testbench

//  Parametrised obstacle generator for the dino game. Scrolls a LINE_W-bit obstacle line.
//  - Obstacles enter at bit 0 and move one position toward bit LINE_W-1 (the player) per scroll tick.
//  - Spawns come from an LFSR, gated by a density threshold and a minimum-gap rule.
//  - Scroll rate is selectable at run time; passed obstacles are counted as score.
//  - Sits between the game controller (enable/speed/clear) and the LED display driver.

---
 rtl/obstacle_scroller.sv | 120 ++++++++++++
 tb/tb_obstacle_scroller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scroller.sv
// Obstacle line generator for the dino game: LFSR-driven spawns scrolled toward the player column.
// Optional collision detection and halt are enabled by defining OBSTACLE_COLLISION_EN.
module obstacle_scroller #(
  parameter int unsigned LINE_W   = 8,
  parameter int unsigned BASE_DIV = 4,
  parameter int unsigned MIN_GAP  = 2,
  parameter int unsigned DENSITY  = 3,
  parameter logic [7:0]  SEED     = 8'hA5,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         speed,
  input  logic               clear,
  input  logic               airborne,
  output logic [LINE_W-1:0]  ledLine,
  output logic               spawn,
  output logic [SCORE_W-1:0] score,
  output logic               collision
);

  localparam int unsigned CNT_W = (BASE_DIV < 2) ? 1 : $clog2(BASE_DIV);
  localparam int unsigned GAP_W = $clog2(MIN_GAP + 2);
  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr;
  logic [CNT_W-1:0]   tick_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [31:0]        period;
  logic               col_hit;
  logic               halted;
  logic               run;
  logic               tick;
  logic               gap_ok;
  logic               dens_ok;
  logic               sbit;

`ifdef OBSTACLE_COLLISION_EN
  assign col_hit = ledLine[LINE_W-1] & ~airborne;
`else
  logic unused_airborne;
  assign unused_airborne = airborne;
  assign col_hit         = 1'b0;
`endif

  // Shift-based divider; speeds beyond the divider width clamp to one tick per clock.
  always_comb begin
    period = 32'(BASE_DIV) >> speed;
    if (period == 32'd0) period = 32'd1;
  end

  assign halted    = (state_q == ST_HALTED);
  assign collision = halted;
  // A collision detected on this edge wins over a coincident tick.
  assign run       = enable & ~halted & ~col_hit & ~clear;
  assign tick      = run & (32'(tick_cnt) >= (period - 32'd1));
  assign gap_ok    = (32'(gap_cnt) >= MIN_GAP);
  assign dens_ok   = (32'(lfsr[2:0]) < DENSITY);
  assign sbit      = gap_ok & dens_ok;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // NOTE: next state is defaulted first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    if (clear)        state_d = ST_RUN;
    else if (col_hit) state_d = ST_HALTED;
  end

  // Free-running Galois LFSR; never reseeded by clear so successive games differ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= SEED_EFF;
    else        lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ledLine  <= '0;
      spawn    <= 1'b0;
      score    <= '0;
      tick_cnt <= '0;
      gap_cnt  <= GAP_W'(MIN_GAP);
    end else if (clear) begin
      ledLine  <= '0;
      spawn    <= 1'b0;
      score    <= '0;
      tick_cnt <= '0;
      gap_cnt  <= GAP_W'(MIN_GAP);
    end else begin
      spawn <= 1'b0;
      if (tick) begin
        tick_cnt <= '0;
        ledLine  <= {ledLine[LINE_W-2:0], sbit};
        spawn    <= sbit;
        if (sbit)
          gap_cnt <= '0;
        else if (gap_cnt != {GAP_W{1'b1}})
          gap_cnt <= gap_cnt + GAP_W'(1);
        // The obstacle leaving the player column is what earns the point.
        if (ledLine[LINE_W-1] && (score != {SCORE_W{1'b1}}))
          score <= score + SCORE_W'(1);
      end else if (run) begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench: three scroller instances (density 8, 0, 3) against a per-cycle arithmetic model,
// with directed steps for the documented sequences followed by randomized control traffic.
module tb_obstacle_scroller;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] speed;
  logic       clear;
  logic       airborne;

  logic [7:0] line_o  [3];
  logic       spawn_o [3];
  logic [7:0] score_o [3];
  logic       col_o   [3];

  int checks = 0;
  int errors = 0;

  localparam int DENS [3] = '{8, 0, 3};
`ifdef OBSTACLE_COLLISION_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  obstacle_scroller #(.DENSITY(8)) u_d8 (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .clear(clear),
    .airborne(airborne), .ledLine(line_o[0]), .spawn(spawn_o[0]),
    .score(score_o[0]), .collision(col_o[0])
  );
  obstacle_scroller #(.DENSITY(0)) u_d0 (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .clear(clear),
    .airborne(airborne), .ledLine(line_o[1]), .spawn(spawn_o[1]),
    .score(score_o[1]), .collision(col_o[1])
  );
  obstacle_scroller u_d3 (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .clear(clear),
    .airborne(airborne), .ledLine(line_o[2]), .spawn(spawn_o[2]),
    .score(score_o[2]), .collision(col_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: line as an integer 0..255, counters as plain ints.
  int m_line [3];
  int m_score[3];
  int m_tcnt [3];
  int m_gap  [3];
  int m_spawn[3];
  int m_col  [3];
  int m_lfsr;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_line[i] = 0; m_score[i] = 0; m_tcnt[i] = 0;
      m_gap[i] = 2;  m_spawn[i] = 0; m_col[i] = 0;
    end
    m_lfsr = 'hA5;
  endtask

  // One rising edge of the game rules, applied to all three instances.
  task automatic model_edge();
    int p;
    bit hit;
    bit sbit;
    p = 4 >> speed;
    if (p == 0) p = 1;
    for (int i = 0; i < 3; i++) begin
      hit = COL_EN && (m_line[i] >= 128) && !airborne;
      if (clear) begin
        m_line[i] = 0; m_score[i] = 0; m_tcnt[i] = 0;
        m_gap[i] = 2;  m_spawn[i] = 0; m_col[i] = 0;
      end else if (!enable || m_col[i] != 0 || hit) begin
        m_spawn[i] = 0;
        if (hit) m_col[i] = 1;
      end else if (m_tcnt[i] >= p - 1) begin
        sbit = (m_gap[i] >= 2) && ((m_lfsr % 8) < DENS[i]);
        if (m_line[i] >= 128 && m_score[i] < 255) m_score[i]++;
        m_line[i]  = (m_line[i] * 2 + int'(sbit)) % 256;
        m_gap[i]   = sbit ? 0 : ((m_gap[i] < 2) ? m_gap[i] + 1 : 2);
        m_tcnt[i]  = 0;
        m_spawn[i] = int'(sbit);
      end else begin
        m_tcnt[i]++;
        m_spawn[i] = 0;
      end
    end
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB8) : (m_lfsr / 2);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.line%0d", tag, i),  int'(line_o[i]),  m_line[i]);
      check($sformatf("%s.spawn%0d", tag, i), int'(spawn_o[i]), m_spawn[i]);
      check($sformatf("%s.score%0d", tag, i), int'(score_o[i]), m_score[i]);
      check($sformatf("%s.col%0d", tag, i),   int'(col_o[i]),   m_col[i]);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int e_line;
    int e_score;
    int n;
    reset = 1'b0; enable = 1'b0; speed = 2'd0; clear = 1'b0; airborne = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.line_const", int'(line_o[0]), 0);

    // Density 8 at speed 0: tick every 4 clocks, fixed spawn pattern.
    reset = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step("seq");
      case (k)
        3:  check("seq.nontick_spawn", int'(spawn_o[0]), 0);
        4:  begin check("seq.tick1_line", int'(line_o[0]), 'h01); check("seq.tick1_spawn", int'(spawn_o[0]), 1); end
        8:  begin check("seq.tick2_line", int'(line_o[0]), 'h02); check("seq.tick2_spawn", int'(spawn_o[0]), 0); end
        12: check("seq.tick3_line", int'(line_o[0]), 'h04);
        16: begin check("seq.tick4_line", int'(line_o[0]), 'h09); check("seq.tick4_spawn", int'(spawn_o[0]), 1); end
        32: check("seq.tick8_score", int'(score_o[0]), 0);
        36: check("seq.tick9_score", int'(score_o[0]), 1);
        default: ;
      endcase
    end

    // Score saturation at full speed.
    speed = 2'd2;
    repeat (900) step("sat");
    check("sat.score_ff", int'(score_o[0]), 255);
    repeat (30) step("sat_hold");
    check("sat.score_hold", int'(score_o[0]), 255);

    // Speed change with tick_cnt already past the new limit.
    clear = 1'b1; step("spd_clr"); clear = 1'b0;
    speed = 2'd0;
    step("spd"); step("spd");
    check("spd.no_tick_yet", int'(line_o[0]), 0);
    speed = 2'd2;
    step("spd_fast");
    check("spd.immediate_tick", int'(spawn_o[0]), 1);
    check("spd.immediate_line", int'(line_o[0]), 'h01);
    speed = 2'd3;
    repeat (5) step("spd3");
    check("spd3.line", int'(line_o[0]), 'h24);

    // Density 0 never spawns; enable=0 freezes the line and score.
    speed = 2'd0;
    repeat (400) step("d0");
    check("d0.line_empty", int'(line_o[1]), 0);
    check("d0.score_zero", int'(score_o[1]), 0);
    enable = 1'b0;
    e_line = m_line[0]; e_score = m_score[0];
    repeat (10) step("frz");
    check("frz.line", int'(line_o[0]), e_line);
    check("frz.score", int'(score_o[0]), e_score);
    check("frz.spawn", int'(spawn_o[0]), 0);
    enable = 1'b1;

    // Clear coincident with a tick.
    n = 0;
    while (m_tcnt[0] != 3 && n < 8) begin step("align"); n++; end
    check("clr.aligned", m_tcnt[0], 3);
    clear = 1'b1;
    step("clr_tick");
    clear = 1'b0;
    check("clr.line", int'(line_o[0]), 0);
    check("clr.score", int'(score_o[0]), 0);
    check("clr.spawn", int'(spawn_o[0]), 0);

    // Asynchronous reset between edges.
    repeat (9) step("pre_rst");
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("arst.line", int'(line_o[0]), 0);
    check("arst.score", int'(score_o[2]), 0);
    check("arst.spawn", int'(spawn_o[0]), 0);
    @(negedge clk);
    check_all("arst");
    reset = 1'b1;

`ifdef OBSTACLE_COLLISION_EN
    // Airborne player lets obstacles pass; grounded player collides and freezes the line.
    airborne = 1'b1;
    repeat (60) step("air");
    check("air.scored", int'(score_o[0] > 0), 1);
    airborne = 1'b0;
    n = 0;
    while (m_col[0] == 0 && n < 60) begin step("gnd"); n++; end
    check("col.set", int'(col_o[0]), 1);
    e_line = m_line[0];
    repeat (8) step("col_hold");
    check("col.frozen", int'(line_o[0]), e_line);
    clear = 1'b1; step("col_clr"); clear = 1'b0;
    check("col.cleared", int'(col_o[0]), 0);
`endif

    // Randomized control traffic against the model.
    for (int k = 0; k < 600; k++) begin
      enable   = ($urandom_range(0, 9) != 0);
      speed    = 2'($urandom_range(0, 3));
      clear    = ($urandom_range(0, 49) == 0);
      airborne = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
